uart_rx: RTL and testbench



---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_rx_fifo.sv | 83 ++++++++
 rtl/uart_rx.sv | 264 ++++++++++++++++++++++++++
 tb/tb_uart_rx.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants and FSM state encoding for the UART receiver
//
// Purpose : common definitions imported by uart_rx and uart_rx_fifo.
// Ports   : none (package).
// Macro   : UART_RX_PARITY_EN adds the PARITY state to the state encoding.
//
// OVERSAMPLE is the number of ticks per bit, MID_SAMPLE the tick within the
// start bit at which the line is re-checked, DATA_BITS the payload width.
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int MID_SAMPLE = 8;
  localparam int DATA_BITS  = 8;

  // Encodings are fixed so the state value is stable whether or not the
  // parity state is compiled in.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
    ST_PARITY = 3'd3,
`endif
    ST_STOP   = 3'd4
  } state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - synchronous first-word-fall-through receive FIFO
//
// Purpose : stores received bytes; the head entry is always visible on
//           pop_data_o while valid_o is high.
// Ports   :
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset (empties the FIFO)
//   push_i       write push_data_i (ignored when full unless popping too)
//   push_data_i  data to write
//   pop_i        remove the head entry (ignored when empty)
//   pop_data_o   head entry, forced to zero while empty
//   valid_o      FIFO non-empty
//   full_o       FIFO holds DEPTH entries
//   count_o      occupancy, 0..DEPTH
//
// DEPTH must be a power of two so the pointers wrap by natural overflow.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = DATA_BITS
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         pop_data_o,
  output logic                     valid_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic             empty;
  logic             do_push;
  logic             do_pop;

  assign empty  = (count_q == '0);
  assign full_o = (count_q == (AW+1)'(DEPTH));

  // A push into a full FIFO is accepted only when the head leaves in the
  // same cycle; the write then lands in the slot being vacated.
  assign do_pop  = pop_i && !empty;
  assign do_push = push_i && (!full_o || do_pop);

  // Storage needs no reset: the output is masked while empty.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign pop_data_o = empty ? '0 : mem_q[rd_ptr_q];
  assign valid_o    = !empty;
  assign count_o    = count_q;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 16x oversampling UART receiver with receive FIFO
//
// Purpose : synchronizes the serial line, recovers 8N1 frames (8E1 with
//           parity compiled in) and queues received bytes in uart_rx_fifo.
// Macro   : UART_RX_PARITY_EN - adds an even-parity bit after the data bits
//           and the parity_err output.
// Ports   :
//   clk          system clock, rising edge
//   reset_n      asynchronous active-low reset
//   rxd          asynchronous serial input, idle high
//   rd_en        pop the FIFO head
//   rd_data      FIFO head (first-word fall-through), zero when empty
//   rd_valid     FIFO non-empty
//   fifo_count   FIFO occupancy
//   frame_err    sticky: stop bit sampled low
//   overrun_err  sticky: byte arrived while the FIFO was full
//   parity_err   sticky: parity mismatch (UART_RX_PARITY_EN only)
//   err_clr      clear all sticky flags (a same-cycle new error wins)
//   busy         receiver state is not IDLE
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_HZ     = 50000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          rxd,
  input  logic                          rd_en,
  output logic [7:0]                    rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_err,
  output logic                          overrun_err,
`ifdef UART_RX_PARITY_EN
  output logic                          parity_err,
`endif
  input  logic                          err_clr,
  output logic                          busy
);

  localparam int DIV   = CLK_HZ / (BAUD * OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TW    = $clog2(OVERSAMPLE);
  localparam int BW    = $clog2(DATA_BITS);

  if (DIV < 1) begin : g_div_check
    $error("uart_rx: CLK_HZ/(BAUD*16) must be at least 1");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_depth_check
    $error("uart_rx: FIFO_DEPTH must be a power of two and at least 2");
  end

  // ---------------------------------------------------------------------
  // Line synchronizer; resets to the idle level so reset never looks like
  // a start bit.
  // ---------------------------------------------------------------------
  logic rxd_meta_q;
  logic rxd_sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
    end else begin
      rxd_meta_q <= rxd;
      rxd_sync_q <= rxd_meta_q;
    end
  end

  // ---------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------
  state_e                 state_q, state_d;
  logic [DIV_W-1:0]       div_q, div_d;
  logic [TW-1:0]          tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   armed_q, armed_d;
  logic                   frame_err_q, frame_err_d;
  logic                   overrun_err_q, overrun_err_d;
`ifdef UART_RX_PARITY_EN
  logic                   parity_bad_q, parity_bad_d;
  logic                   parity_err_q, parity_err_d;
  logic                   parity_evt;
`endif

  logic                   tick;
  logic                   mid_tick;
  logic                   bit_tick;
  logic                   push;
  logic                   frame_evt;
  logic                   overrun_evt;
  logic                   fifo_full;

  // ---------------------------------------------------------------------
  // Tick generator: one pulse every DIV clocks. Held at zero in IDLE so the
  // tick phase restarts exactly at the detected falling edge.
  // ---------------------------------------------------------------------
  assign tick = (div_q == DIV_W'(DIV - 1));

  always_comb begin
    div_d = div_q + DIV_W'(1);
    if (state_q == ST_IDLE || tick) begin
      div_d = '0;
    end
  end

  assign mid_tick = tick && (tick_cnt_q == TW'(MID_SAMPLE - 1));
  assign bit_tick = tick && (tick_cnt_q == TW'(OVERSAMPLE - 1));

  // ---------------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick ? tick_cnt_q + TW'(1) : tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    armed_d    = armed_q;
    push       = 1'b0;
    frame_evt  = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_bad_d = parity_bad_q;
    parity_evt   = 1'b0;
`endif

    case (state_q)
      ST_IDLE: begin
        tick_cnt_d = '0;
        bit_cnt_d  = '0;
        // armed_q is dropped after every frame and by reset; only a high
        // line re-arms it, so a held-low break cannot start a new frame.
        if (rxd_sync_q) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          state_d = ST_START;
        end
      end

      ST_START: begin
        if (mid_tick) begin
          tick_cnt_d = '0;
          // A high line at mid start bit was only a glitch.
          state_d = rxd_sync_q ? ST_IDLE : ST_DATA;
        end
      end

      ST_DATA: begin
        if (bit_tick) begin
          tick_cnt_d = '0;
          shift_d    = {rxd_sync_q, shift_q[DATA_BITS-1:1]};
          bit_cnt_d  = bit_cnt_q + BW'(1);
          if (bit_cnt_q == BW'(DATA_BITS - 1)) begin
`ifdef UART_RX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end

`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (bit_tick) begin
          tick_cnt_d   = '0;
          parity_bad_d = rxd_sync_q ^ (^shift_q);
          parity_evt   = parity_bad_d;
          state_d      = ST_STOP;
        end
      end
`endif

      ST_STOP: begin
        if (bit_tick) begin
          tick_cnt_d = '0;
          state_d    = ST_IDLE;
          armed_d    = 1'b0;
          if (rxd_sync_q) begin
`ifdef UART_RX_PARITY_EN
            push = !parity_bad_q;
`else
            push = 1'b1;
`endif
          end else begin
            frame_evt = 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // A push that the FIFO cannot absorb (full and no simultaneous read).
  assign overrun_evt = push && fifo_full && !rd_en;

  // Sticky flags: a new event in the clearing cycle keeps the flag set.
  assign frame_err_d   = (frame_err_q & ~err_clr) | frame_evt;
  assign overrun_err_d = (overrun_err_q & ~err_clr) | overrun_evt;
`ifdef UART_RX_PARITY_EN
  assign parity_err_d  = (parity_err_q & ~err_clr) | parity_evt;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      div_q         <= '0;
      tick_cnt_q    <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      armed_q       <= 1'b0;
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bad_q  <= 1'b0;
      parity_err_q  <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      div_q         <= div_d;
      tick_cnt_q    <= tick_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      armed_q       <= armed_d;
      frame_err_q   <= frame_err_d;
      overrun_err_q <= overrun_err_d;
`ifdef UART_RX_PARITY_EN
      parity_bad_q  <= parity_bad_d;
      parity_err_q  <= parity_err_d;
`endif
    end
  end

  // ---------------------------------------------------------------------
  // Receive FIFO
  // ---------------------------------------------------------------------
  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_BITS)
  ) u_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .push_i      (push),
    .push_data_i (shift_q),
    .pop_i       (rd_en),
    .pop_data_o  (rd_data),
    .valid_o     (rd_valid),
    .full_o      (fifo_full),
    .count_o     (fifo_count)
  );

  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_err_q;
`ifdef UART_RX_PARITY_EN
  assign parity_err  = parity_err_q;
`endif
  assign busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - self-checking bench for uart_rx (16 clocks per bit)
module tb_uart_rx;

  localparam int CLK_HZ   = 1600000;
  localparam int BAUD     = 100000;
  localparam int DEPTH    = 8;
  localparam int BIT_CLKS = 16;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  // Clock index (counted from the negedge that drives the start bit) of the
  // stop-bit sample: two synchronizer clocks, then 8 ticks to mid start
  // bit, then 16 ticks for each following bit.
  localparam int STOP_N = 2 + 8 + (NBITS - 1) * BIT_CLKS;

  logic       clk;
  logic       reset_n;
  logic       rxd;
  logic       rd_en;
  logic       err_clr;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [3:0] fifo_count;
  logic       frame_err;
  logic       overrun_err;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  uart_rx #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .rxd         (rxd),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .fifo_count  (fifo_count),
    .frame_err   (frame_err),
    .overrun_err (overrun_err),
`ifdef UART_RX_PARITY_EN
    .parity_err  (parity_err),
`endif
    .err_clr     (err_clr),
    .busy        (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: the bytes the FIFO should hold and the sticky flags.
  logic [7:0] q[$];
  logic       m_ferr;
  logic       m_ovr;
  logic       m_perr;
  int         total;
  int         bad;

  typedef struct {
    logic [7:0] data;
    logic [3:0] exp_count;
    logic       exp_ovr;
  } vec_t;
  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, "_count"}, 32'(fifo_count), 32'(q.size()));
    check({tag, "_valid"}, 32'(rd_valid), 32'(q.size() != 0));
    if (q.size() != 0) check({tag, "_head"}, 32'(rd_data), 32'(q[0]));
    check({tag, "_ferr"}, 32'(frame_err), 32'(m_ferr));
    check({tag, "_ovr"}, 32'(overrun_err), 32'(m_ovr));
`ifdef UART_RX_PARITY_EN
    check({tag, "_perr"}, 32'(parity_err), 32'(m_perr));
`endif
  endtask

  task automatic model_frame(input logic [7:0] data, input logic stop, input logic par_flip);
    if (par_flip) m_perr = 1'b1;
    if (!stop) m_ferr = 1'b1;
    else if (!par_flip) begin
      if (q.size() < DEPTH) q.push_back(data);
      else m_ovr = 1'b1;
    end
  endtask

  // mode: 0 plain, 1 check rd_valid around the stop sample, 2 rd_en on the
  // stop-sample clock, 3 err_clr on the stop-sample clock, 4 reset at bit 4.
  task automatic send_frame(input logic [7:0] data, input logic stop,
                            input logic par_flip, input int mode);
    logic [NBITS-1:0] bits;
    bits = '0;
    for (int i = 0; i < 8; i++) bits[1+i] = data[i];
`ifdef UART_RX_PARITY_EN
    bits[9] = (^data) ^ par_flip;
`endif
    bits[NBITS-1] = stop;
    for (int n = 0; n < NBITS * BIT_CLKS; n++) begin
      @(negedge clk);
      if (n % BIT_CLKS == 0) rxd = bits[n / BIT_CLKS];
      if (n == STOP_N) begin
        if (mode == 1) check("valid_before_stop", 32'(rd_valid), 32'd0);
        if (mode == 2) begin
          rd_en = 1'b1;
          if (q.size() != 0) begin
            check("push_pop_head", 32'(rd_data), 32'(q[0]));
            void'(q.pop_front());
          end
        end
        if (mode == 3) begin
          err_clr = 1'b1;
          m_ferr = 1'b0;
          m_ovr  = 1'b0;
          m_perr = 1'b0;
        end
      end
      if (n == STOP_N + 1) begin
        rd_en   = 1'b0;
        err_clr = 1'b0;
        if (mode == 1) check("valid_after_stop", 32'(rd_valid), 32'd1);
      end
      if (mode == 4 && n == 5 * BIT_CLKS) begin
        check("rst_busy_before", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_valid", 32'(rd_valid), 32'd0);
        check("rst_data", 32'(rd_data), 32'd0);
        check("rst_ferr", 32'(frame_err), 32'd0);
        q.delete();
        m_ferr = 1'b0;
        m_ovr  = 1'b0;
        m_perr = 1'b0;
      end
      if (mode == 4 && n == 5 * BIT_CLKS + 3) reset_n = 1'b1;
    end
    if (mode != 4) model_frame(data, stop, par_flip);
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic read_one(input string tag);
    if (q.size() != 0) begin
      check({tag, "_rd_valid"}, 32'(rd_valid), 32'd1);
      check({tag, "_rd_data"}, 32'(rd_data), 32'(q[0]));
      void'(q.pop_front());
    end else begin
      check({tag, "_rd_empty"}, 32'(rd_valid), 32'd0);
    end
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic clear_errs();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
    m_perr = 1'b0;
  endtask

  initial begin
    #100000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad = 0;
    m_ferr = 1'b0;
    m_ovr = 1'b0;
    m_perr = 1'b0;
    rxd = 1'b1;
    rd_en = 1'b0;
    err_clr = 1'b0;
    reset_n = 1'b0;
    for (int i = 0; i < 9; i++) begin
      vecs[i].data      = 8'(i + 1);
      vecs[i].exp_count = (i < 8) ? 4'(i + 1) : 4'd8;
      vecs[i].exp_ovr   = (i == 8);
    end

    repeat (3) @(negedge clk);
    check("reset_valid", 32'(rd_valid), 32'd0);
    check("reset_count", 32'(fifo_count), 32'd0);
    check("reset_data", 32'(rd_data), 32'd0);
    check("reset_ferr", 32'(frame_err), 32'd0);
    check("reset_ovr", 32'(overrun_err), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    reset_n = 1'b1;
    idle(4);

    // Single 0xA5 frame with exact arrival timing.
    send_frame(8'hA5, 1'b1, 1'b0, 1);
    idle(8);
    check("a5_data", 32'(rd_data), 32'hA5);
    check_state("a5");
    read_one("a5");
    check_state("a5_drained");

    // Five-clock glitch on an idle line.
    rxd = 1'b0;
    repeat (4) @(negedge clk);
    check("glitch_busy", 32'(busy), 32'd1);
    @(negedge clk);
    idle(24);
    check("glitch_idle", 32'(busy), 32'd0);
    check_state("glitch");

    // Bad stop bit followed by a held-low break: no retrigger.
    send_frame(8'h3C, 1'b0, 1'b0, 0);
    rxd = 1'b0;
    repeat (40) @(negedge clk);
    check("break_no_retrigger", 32'(busy), 32'd0);
    idle(8);
    check_state("ferr");
    clear_errs();
    check_state("ferr_clr");

    // Clear and new frame error in the same cycle: the error wins.
    send_frame(8'h66, 1'b0, 1'b0, 3);
    idle(8);
    check("clr_vs_event", 32'(frame_err), 32'd1);
    check_state("clr_vs_event");
    clear_errs();

    // Nine frames without reads: the ninth overruns.
    for (int i = 0; i < 9; i++) begin
      send_frame(vecs[i].data, 1'b1, 1'b0, 0);
      idle(8);
      check($sformatf("fill%0d_count", i), 32'(fifo_count), 32'(vecs[i].exp_count));
      check($sformatf("fill%0d_ovr", i), 32'(overrun_err), 32'(vecs[i].exp_ovr));
    end
    for (int i = 0; i < 8; i++) read_one($sformatf("drain%0d", i));
    read_one("empty_read");
    check_state("drained");
    clear_errs();

    // Full FIFO with a read on the push clock of 0x55.
    for (int i = 0; i < 8; i++) begin
      send_frame(8'(8'h20 + i), 1'b1, 1'b0, 0);
      idle(8);
    end
    send_frame(8'h55, 1'b1, 1'b0, 2);
    idle(8);
    check("full_rd_ovr", 32'(overrun_err), 32'd0);
    check("full_rd_count", 32'(fifo_count), 32'd8);
    for (int i = 0; i < 7; i++) read_one($sformatf("full_rd%0d", i));
    check("last_read_55", 32'(rd_data), 32'h55);
    read_one("full_rd_last");
    check_state("full_rd_done");

    // Reset in the middle of 0xFF, then 0x12 is the only byte received.
    send_frame(8'h77, 1'b1, 1'b0, 0);
    idle(8);
    send_frame(8'hFF, 1'b1, 1'b0, 4);
    idle(8);
    send_frame(8'h12, 1'b1, 1'b0, 0);
    idle(8);
    check("after_rst_count", 32'(fifo_count), 32'd1);
    check("after_rst_data", 32'(rd_data), 32'h12);
    check_state("after_rst");
    read_one("after_rst");

`ifdef UART_RX_PARITY_EN
    send_frame(8'h12, 1'b1, 1'b1, 0);
    idle(8);
    check("parity_flag", 32'(parity_err), 32'd1);
    check("parity_discard", 32'(fifo_count), 32'd0);
    check_state("parity");
    clear_errs();
`endif

    // Randomized frames and reads against the model.
    for (int r = 0; r < 24; r++) begin
      logic [7:0] d;
      logic       s;
      int         nrd;
      d   = 8'($urandom);
      s   = ($urandom_range(0, 7) != 0);
      nrd = $urandom_range(0, 2);
      send_frame(d, s, 1'b0, 0);
      idle(8);
      check_state($sformatf("rand%0d", r));
      for (int k = 0; k < nrd; k++) read_one($sformatf("rand%0d_%0d", r, k));
    end
    for (int k = 0; k < DEPTH; k++) begin
      if (q.size() != 0) read_one($sformatf("final%0d", k));
    end
    check_state("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
